// File: rtl/display_source_sequencer.sv
// N-channel display/alarm source sequencer.
// Selects one of NUM_CH sensor words for the hex displays and buzzer mode.
// The channel advances on a debounced push-button or on an auto-scan dwell
// timer; every switch blanks the output for BLANK_CYCLES cycles.
`timescale 1ns/1ps
module display_source_sequencer #(
  parameter int NUM_CH         = 4,
  parameter int DATA_W         = 16,
  parameter int DEBOUNCE_TICKS = 500000,
  parameter int SCAN_TICKS     = 50000000,
  parameter int BLANK_CYCLES   = 4,
  localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic [NUM_CH-1:0]        ch_valid,
  input  logic                     btn_next,
  input  logic                     auto_scan,
  output logic [DATA_W-1:0]        selected_data,
  output logic                     data_valid,
  output logic [CH_W-1:0]          selected_ch,
  output logic [CH_W-1:0]          buzzer_mode,
  output logic                     switch_pulse
);

  localparam int DB_W = $clog2(DEBOUNCE_TICKS + 1);
  localparam int SC_W = $clog2(SCAN_TICKS + 1);
  localparam int BL_W = $clog2(BLANK_CYCLES + 1);

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_TICKS - 1);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(SCAN_TICKS - 1);
  localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLANK_CYCLES - 1);
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CH - 1);

  typedef enum logic {
    SHOW  = 1'b0,
    BLANK = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic              btn_s1_q, btn_s2_q;
  logic              deb_q, deb_d;
  logic              deb_prev_q;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [SC_W-1:0]   scan_q, scan_d;
  logic [BL_W-1:0]   blank_q, blank_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [CH_W-1:0]   buzz_q;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              pulse_q, pulse_d;

  logic              btn_req;
  logic              timer_req;
  logic              req;
  logic              cur_valid;
  logic [DATA_W-1:0] cur_word;

  // Two-flop synchroniser for the asynchronous push-button.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_s1_q <= 1'b0;
      btn_s2_q <= 1'b0;
    end else begin
      btn_s1_q <= btn_next;
      btn_s2_q <= btn_s1_q;
    end
  end

  // Debouncer: accept a new level only after it has differed for DEBOUNCE_TICKS cycles in a row.
  always_comb begin
    deb_d    = deb_q;
    db_cnt_d = '0;
    if (btn_s2_q != deb_q) begin
      if (db_cnt_q == DB_LAST) begin
        deb_d    = btn_s2_q;
        db_cnt_d = '0;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  // Debounced level, its one-cycle-delayed copy for edge detection, and the stability counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      db_cnt_q   <= '0;
    end else begin
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      db_cnt_q   <= db_cnt_d;
    end
  end

  assign btn_req   = deb_q & ~deb_prev_q;
  assign timer_req = auto_scan && (state_q == SHOW) && (scan_q == SC_LAST);
  assign req       = btn_req | timer_req;

  // Pick out the strobe and word of the currently selected channel.
  always_comb begin
    cur_valid = 1'b0;
    cur_word  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (CH_W'(k) == ch_q) begin
        cur_valid = ch_valid[k];
        cur_word  = ch_data[k*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state and output logic: SHOW tracks the channel, BLANK forces zeros after a switch.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    data_d  = data_q;
    valid_d = valid_q;
    pulse_d = 1'b0;
    blank_d = blank_q;
    scan_d  = '0;
    case (state_q)
      SHOW: begin
        if (req) begin
          state_d = BLANK;
          ch_d    = (ch_q == CH_LAST) ? '0 : ch_q + CH_W'(1);
          data_d  = '0;
          valid_d = 1'b0;
          pulse_d = 1'b1;
          blank_d = BL_LAST;
        end else begin
          if (cur_valid) begin
            data_d  = cur_word;
            valid_d = 1'b1;
          end
          if (auto_scan) begin
            scan_d = scan_q + SC_W'(1);
          end
        end
      end
      BLANK: begin
        data_d  = '0;
        valid_d = 1'b0;
        if (blank_q == '0) begin
          state_d = SHOW;
        end else begin
          blank_d = blank_q - BL_W'(1);
        end
      end
      default: begin
        state_d = SHOW;
      end
    endcase
  end

  // State, channel index, buzzer mode, output data and timers; reset abandons any blank or scan.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SHOW;
      ch_q    <= '0;
      buzz_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      pulse_q <= 1'b0;
      blank_q <= '0;
      scan_q  <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      buzz_q  <= ch_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      pulse_q <= pulse_d;
      blank_q <= blank_d;
      scan_q  <= scan_d;
    end
  end

  assign selected_data = data_q;
  assign data_valid    = valid_q;
  assign selected_ch   = ch_q;
  assign buzzer_mode   = buzz_q;
  assign switch_pulse  = pulse_q;

endmodule

// File: tb/tb_display_source_sequencer.sv
// Self-checking bench for display_source_sequencer (3 channels, short timers).
`timescale 1ns/1ps
module tb_display_source_sequencer;

  localparam int NUM_CH = 3;
  localparam int DATA_W = 16;
  localparam int DEB    = 4;
  localparam int SCAN   = 10;
  localparam int BLANK  = 2;
  localparam int CH_W   = 2;

  logic                     clk;
  logic                     reset;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic [NUM_CH-1:0]        ch_valid;
  logic                     btn_next;
  logic                     auto_scan;
  logic [DATA_W-1:0]        selected_data;
  logic                     data_valid;
  logic [CH_W-1:0]          selected_ch;
  logic [CH_W-1:0]          buzzer_mode;
  logic                     switch_pulse;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_ch   = 0;

  display_source_sequencer #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEBOUNCE_TICKS(DEB),
    .SCAN_TICKS(SCAN), .BLANK_CYCLES(BLANK)
  ) dut (
    .clk(clk), .reset(reset), .ch_data(ch_data), .ch_valid(ch_valid),
    .btn_next(btn_next), .auto_scan(auto_scan),
    .selected_data(selected_data), .data_valid(data_valid),
    .selected_ch(selected_ch), .buzzer_mode(buzzer_mode),
    .switch_pulse(switch_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    ch_valid  = '0;
    ch_data   = '0;
    btn_next  = 1'b0;
    auto_scan = 1'b0;
    reset     = 1'b1;
    tick();
    tick();
    @(negedge clk);
    reset = 1'b0;
    tick();
    exp_ch = 0;
  endtask

  // Press and hold the button, then release and let the release settle.
  task automatic press_btn(output int lat, output int npulse);
    lat    = -1;
    npulse = 0;
    btn_next = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (switch_pulse) begin
        npulse++;
        if (lat < 0) lat = i;
      end
    end
    btn_next = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (switch_pulse) npulse++;
    end
  endtask

  task automatic test_reset();
    int lat, np;
    logic [DATA_W-1:0] w;
    do_reset();
    n_checks++;
    if (selected_ch !== 2'd0 || data_valid !== 1'b0 || selected_data !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_initial: ch=%0d valid=%0b data=%0h required 0/0/0", selected_ch, data_valid, selected_data);
    end
    press_btn(lat, np);
    press_btn(lat, np);
    n_checks++;
    if (selected_ch !== 2'd2) begin
      n_fail++;
      $display("FAIL reset_setup_ch: got %0d required 2", selected_ch);
    end
    w = 16'($urandom) | 16'h0001;
    ch_data[2*DATA_W +: DATA_W] = w;
    ch_valid = 3'b100;
    tick();
    ch_valid = '0;
    n_checks++;
    if (selected_data !== w || data_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_setup_data: got %0h/%0b required %0h/1", selected_data, data_valid, w);
    end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (selected_ch !== 2'd0 || buzzer_mode !== 2'd0 || selected_data !== 16'h0 ||
        data_valid !== 1'b0 || switch_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: ch=%0d buzz=%0d data=%0h valid=%0b pulse=%0b required all 0",
               selected_ch, buzzer_mode, selected_data, data_valid, switch_pulse);
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
    exp_ch = 0;
    ch_data[0 +: DATA_W] = 16'h1234;
    ch_valid = 3'b001;
    tick();
    ch_valid = '0;
    n_checks++;
    if (selected_data !== 16'h1234 || data_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first_word: got %0h/%0b required 1234/1", selected_data, data_valid);
    end
  endtask

  task automatic test_debounce();
    int lat, np;
    do_reset();
    btn_next = 1'b1; tick();
    btn_next = 1'b0; tick();
    btn_next = 1'b1;
    lat = -1;
    np  = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (switch_pulse) begin
        np++;
        if (lat < 0) lat = i;
      end
    end
    n_checks++;
    if (lat !== DEB + 3) begin
      n_fail++;
      $display("FAIL debounce_latency: got %0d cycles required %0d", lat, DEB + 3);
    end
    n_checks++;
    if (np !== 1) begin
      n_fail++;
      $display("FAIL debounce_pulse_count: got %0d required 1", np);
    end
    exp_ch = (exp_ch + 1) % NUM_CH;
    n_checks++;
    if (selected_ch !== CH_W'(exp_ch) || buzzer_mode !== CH_W'(exp_ch)) begin
      n_fail++;
      $display("FAIL debounce_ch: ch=%0d buzz=%0d required %0d", selected_ch, buzzer_mode, exp_ch);
    end
    btn_next = 1'b0;
    repeat (10) tick();
    btn_next = 1'b1;
    repeat (DEB - 1) tick();
    btn_next = 1'b0;
    np = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (switch_pulse) np++;
    end
    n_checks++;
    if (np !== 0 || selected_ch !== CH_W'(exp_ch)) begin
      n_fail++;
      $display("FAIL debounce_glitch: pulses=%0d ch=%0d required 0/%0d", np, selected_ch, exp_ch);
    end
  endtask

  task automatic test_wrap_blank();
    logic [DATA_W-1:0] w, w2, drop;
    int found;
    do_reset();
    for (int p = 0; p < 3; p++) begin
      w = 16'($urandom) | 16'h0001;
      ch_data[exp_ch*DATA_W +: DATA_W] = w;
      ch_valid = '0;
      ch_valid[exp_ch] = 1'b1;
      tick();
      ch_valid = '0;
      n_checks++;
      if (selected_data !== w || data_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL wrap_pre_data[%0d]: got %0h/%0b required %0h/1", p, selected_data, data_valid, w);
      end
      btn_next = 1'b1;
      found = 0;
      for (int i = 0; i < 20; i++) begin
        tick();
        if (switch_pulse) begin
          found = 1;
          break;
        end
      end
      exp_ch = (exp_ch + 1) % NUM_CH;
      n_checks++;
      if (found != 1) begin
        n_fail++;
        $display("FAIL wrap_pulse_timeout[%0d]: no switch_pulse in 20 cycles required one", p);
      end
      n_checks++;
      if (selected_ch !== CH_W'(exp_ch) || buzzer_mode !== CH_W'(exp_ch) ||
          selected_data !== 16'h0 || data_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL wrap_switch[%0d]: ch=%0d buzz=%0d data=%0h valid=%0b required %0d/%0d/0/0",
                 p, selected_ch, buzzer_mode, selected_data, data_valid, exp_ch, exp_ch);
      end
      drop = 16'($urandom) | 16'h0001;
      ch_data[exp_ch*DATA_W +: DATA_W] = drop;
      ch_valid[exp_ch] = 1'b1;
      tick();
      ch_valid = '0;
      n_checks++;
      if (selected_data !== 16'h0 || data_valid !== 1'b0 || switch_pulse !== 1'b0) begin
        n_fail++;
        $display("FAIL wrap_blank2[%0d]: data=%0h valid=%0b pulse=%0b required 0/0/0",
                 p, selected_data, data_valid, switch_pulse);
      end
      tick();
      tick();
      n_checks++;
      if (selected_data !== 16'h0 || data_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL wrap_dropped_strobe[%0d]: data=%0h valid=%0b required 0/0", p, selected_data, data_valid);
      end
      w2 = 16'($urandom) | 16'h0001;
      ch_data[exp_ch*DATA_W +: DATA_W] = w2;
      ch_valid[exp_ch] = 1'b1;
      tick();
      ch_valid = '0;
      n_checks++;
      if (selected_data !== w2 || data_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL wrap_post_data[%0d]: got %0h/%0b required %0h/1", p, selected_data, data_valid, w2);
      end
      btn_next = 1'b0;
      repeat (9) tick();
    end
  endtask

  task automatic test_auto_scan();
    int next_p, pulses, drop_at;
    logic exp_p;
    do_reset();
    auto_scan = 1'b1;
    next_p  = SCAN;
    pulses  = 0;
    drop_at = -10;
    for (int t = 1; t <= 70; t++) begin
      tick();
      exp_p = (t == next_p);
      n_checks++;
      if (switch_pulse !== exp_p) begin
        n_fail++;
        $display("FAIL auto_pulse@%0d: got %0b required %0b", t, switch_pulse, exp_p);
      end
      if (exp_p) begin
        pulses++;
        exp_ch = (exp_ch + 1) % NUM_CH;
        n_checks++;
        if (selected_ch !== CH_W'(exp_ch) || buzzer_mode !== CH_W'(exp_ch)) begin
          n_fail++;
          $display("FAIL auto_ch@%0d: ch=%0d buzz=%0d required %0d", t, selected_ch, buzzer_mode, exp_ch);
        end
        next_p = t + BLANK + SCAN;
        if (pulses == 4) drop_at = t + 2 + int'($urandom_range(0, 7));
      end
      if (t == drop_at) auto_scan = 1'b0;
      if (t == drop_at + 1) begin
        auto_scan = 1'b1;
        next_p = t + SCAN;
      end
    end
    n_checks++;
    if (pulses != 5) begin
      n_fail++;
      $display("FAIL auto_model_count: model saw %0d pulses required 5", pulses);
    end
    auto_scan = 1'b0;
    repeat (5) tick();
  endtask

  task automatic test_collision();
    int np;
    logic exp_p;
    do_reset();
    auto_scan = 1'b1;
    repeat (3) tick();
    btn_next = 1'b1;
    np = 0;
    for (int t = 4; t <= 25; t++) begin
      tick();
      exp_p = (t == SCAN) || (t == 2 * SCAN + BLANK);
      if (switch_pulse) np++;
      n_checks++;
      if (switch_pulse !== exp_p) begin
        n_fail++;
        $display("FAIL collision_pulse@%0d: got %0b required %0b", t, switch_pulse, exp_p);
      end
      if (t == SCAN) begin
        n_checks++;
        if (selected_ch !== 2'd1) begin
          n_fail++;
          $display("FAIL collision_ch: got %0d required 1", selected_ch);
        end
      end
    end
    n_checks++;
    if (np != 2 || selected_ch !== 2'd2) begin
      n_fail++;
      $display("FAIL collision_total: pulses=%0d ch=%0d required 2/2", np, selected_ch);
    end
    btn_next  = 1'b0;
    auto_scan = 1'b0;
    repeat (10) tick();
  endtask

  task automatic test_hold();
    int lat, np;
    logic [DATA_W-1:0] exp_data, w;
    logic [NUM_CH-1:0] v;
    do_reset();
    press_btn(lat, np);
    n_checks++;
    if (selected_ch !== 2'd1 || np != 1) begin
      n_fail++;
      $display("FAIL hold_setup: ch=%0d pulses=%0d required 1/1", selected_ch, np);
    end
    w = 16'($urandom) | 16'h0001;
    ch_data[1*DATA_W +: DATA_W] = w;
    ch_valid = 3'b010;
    tick();
    ch_valid = '0;
    exp_data = w;
    n_checks++;
    if (selected_data !== exp_data || data_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_first: got %0h/%0b required %0h/1", selected_data, data_valid, exp_data);
    end
    for (int i = 0; i < 30; i++) begin
      ch_data = {16'($urandom), 16'($urandom), 16'($urandom)};
      v = 3'($urandom_range(0, 7));
      if (i < 10) v[1] = 1'b0;
      ch_valid = v;
      if (v[1]) exp_data = ch_data[1*DATA_W +: DATA_W];
      tick();
      ch_valid = '0;
      n_checks++;
      if (selected_data !== exp_data || data_valid !== 1'b1 || selected_ch !== 2'd1) begin
        n_fail++;
        $display("FAIL hold[%0d]: data=%0h valid=%0b ch=%0d required %0h/1/1",
                 i, selected_data, data_valid, selected_ch, exp_data);
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    ch_data   = '0;
    ch_valid  = '0;
    btn_next  = 1'b0;
    auto_scan = 1'b0;
    test_reset();
    test_debounce();
    test_wrap_blank();
    test_auto_scan();
    test_collision();
    test_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
